fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage between the program counter and the decode stage.
- Drives instruction-memory requests from the current PC and produces the PC enable/next-PC back to the PC register.
- Captures fetched words into an IF/ID output register backed by a one-entry skid buffer, so decode back-pressure never loses a hit.
- Handles branch/jump redirects (squash) and the halt condition.

Parameters:
- WORD_W, 32, instruction and address width.
- RESET_VALID, 0, reset value of ifid_valid (kept 0; exposed for bench only).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- curr_pc  in  WORD_W  PC register current value
- npc  in  WORD_W  curr_pc+4 from PC register
- pc_en  out  1  load enable to PC register
- new_pc  out  WORD_W  value PC register loads when pc_en=1
- iREN  out  1  instruction read request
- iaddr  out  WORD_W  instruction address (= curr_pc)
- ihit  in  1  memory returns iload this cycle
- iload  in  WORD_W  fetched instruction word
- stall  in  1  decode cannot accept ifid this cycle
- redirect  in  1  branch/jump resolved taken; flush fetch path
- redirect_pc  in  WORD_W  redirect target
- halt_req  in  1  decode saw HALT; stop fetching
- ifid_valid  out  1  output register holds a live instruction
- ifid_instr  out  WORD_W  instruction
- ifid_pc  out  WORD_W  PC of instruction
- ifid_npc  out  WORD_W  PC+4 of instruction
- halted  out  1  fetch stopped permanently

Behaviour:
- Reset is decided: nRST, asynchronous, active-low; clock CLK.
- On reset: state=RUN, ifid_valid=0, skid_valid=0, ifid_instr/pc/npc=0, halted=0.
- States: RUN, HALTED.
  - RUN->HALTED when halt_req=1 and redirect=0.
  - HALTED is exited only by reset.
- Combinational signals:
  - iaddr=curr_pc always.
  - iREN = (state==RUN) & !skid_valid & !halt_req.
  - fire = iREN & ihit.
  - accept = !ifid_valid | !stall.
- Redirect (RUN only; highest priority, overrides stall, fire and halt_req):
  - pc_en=1, new_pc=redirect_pc.
  - Next edge: ifid_valid<=0, skid_valid<=0.
  - Any fire in the same cycle is squashed.
- Normal path (no redirect): pc_en=fire, new_pc=npc. The PC advances exactly once per accepted fetch.
- Next-state rules:
  - accept & skid_valid: ifid<=skid, skid_valid<=0.
  - accept & !skid_valid & fire: ifid<={1,iload,curr_pc,npc}.
  - accept & !skid_valid & !fire: ifid_valid<=0 (bubble).
  - !accept & fire: skid<={iload,curr_pc,npc}, skid_valid<=1; ifid unchanged.
  - !accept & !fire: hold everything.
- Zero-bubble throughput: one instruction per cycle when ihit=1 and stall=0. Latency from ihit to ifid_valid is 1 cycle.
- Skid is full only while stall holds. iREN stays 0 until the skid drains, so no third entry is ever needed.
- HALTED:
  - iREN=0, pc_en=0, redirect ignored, halted=1 (registered, 1 cycle after the halt_req edge).
  - ifid/skid still drain normally under !stall, then ifid_valid stays 0.
- Reset mid-operation: all state cleared asynchronously. Any in-flight fetch is dropped with no PC update.
- ihit while iREN=0 is ignored.
- PC arithmetic is owned by the PC register; this block never adds.

Decomposition:
- Shared package cpu_types_pkg gains:
  - word_t (already present).
  - fetch_state_t enum {RUN, HALTED}.
  - ifid_t struct {instr, pc, npc}.
- New interface fetch_stage_if carries the ports above, with modports fs (this block) and tb.
- One natural sub-module, ifid_skid_reg: a 2-entry (output + skid) valid/ready register with flush, parameterised on ifid_t. fetch_stage instantiates it and keeps the FSM and PC control.

Test Plan:
- Streaming: curr_pc=0x0, ihit=1 every cycle, stall=0, iload=0xA0..A3 -> pc_en=1 each cycle; ifid shows (0xA0,pc 0x0,npc 0x4), then (0xA1,0x4,0x8)... one per cycle, no bubbles.
- Back-pressure: ifid holds 0xA0, stall=1, ihit=1 with iload=0xA1 at pc 0x4.
  - Required: skid captures 0xA1, pc_en=1 once, iREN=0 next cycle, ifid stays 0xA0.
  - Drop stall: ifid=0xA1 next cycle, then fetch resumes at 0x8.
- Miss wait: ihit=0 for 3 cycles at pc 0x10 -> pc_en=0, iREN=1, ifid_valid=0. ihit=1 with 0xBEEF -> ifid=(0xBEEF,0x10,0x14).
- Redirect with hit and stall: redirect=1, redirect_pc=0x200 while ihit=1, stall=1, skid full.
  - Required: pc_en=1, new_pc=0x200; next cycle ifid_valid=0, skid_valid=0; no squashed word appears.
- Halt: halt_req=1 at pc 0x30 -> iREN=0 same cycle, halted=1 next cycle, pc_en stays 0 for 10 cycles, redirect=1 ignored.
- Async reset mid-skid: nRST low between clock edges with skid and ifid full -> ifid_valid=0, skid_valid=0, halted=0 immediately, before any clock edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the IF/ID payload.
package cpu_types_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch-stage signals; fs is the stage side, tb the environment side.
interface fetch_stage_if #(
  parameter int unsigned WORD_W = cpu_types_pkg::WORD_BITS
) (
  input logic CLK,
  input logic nRST
);
  logic [WORD_W-1:0] curr_pc;
  logic [WORD_W-1:0] npc;
  logic              pc_en;
  logic [WORD_W-1:0] new_pc;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt_req;
  logic              ifid_valid;
  logic [WORD_W-1:0] ifid_instr;
  logic [WORD_W-1:0] ifid_pc;
  logic [WORD_W-1:0] ifid_npc;
  logic              halted;

  modport fs (
    input  CLK, nRST, curr_pc, npc, ihit, iload, stall, redirect, redirect_pc, halt_req,
    output pc_en, new_pc, iREN, iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, halted
  );

  modport tb (
    input  CLK, nRST, pc_en, new_pc, iREN, iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, halted,
    output curr_pc, npc, ihit, iload, stall, redirect, redirect_pc, halt_req
  );
endinterface

// File: rtl/ifid_skid_reg.sv
// Output register plus one-entry skid buffer; a word offered while the output
// is blocked parks in the skid and is handed over as soon as the consumer accepts.
module ifid_skid_reg
  import cpu_types_pkg::*;
#(
  parameter type T           = ifid_t,
  parameter bit  RESET_VALID = 1'b0
) (
  input  logic CLK,
  input  logic nRST,
  input  logic flush_i,
  input  logic in_valid_i,
  input  T     in_data_i,
  input  logic out_ready_i,
  output logic out_valid_o,
  output T     out_data_o,
  output logic skid_valid_o
);

  logic out_valid_q, out_valid_d;
  T     out_data_q,  out_data_d;
  logic skid_valid_q, skid_valid_d;
  T     skid_data_q,  skid_data_d;
  logic accept;

  assign accept = !out_valid_q || out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_valid_i) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_q  <= RESET_VALID;
      out_data_q   <= T'('0);
      skid_valid_q <= 1'b0;
      skid_data_q  <= T'('0);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues I-mem reads at curr_pc, steers the PC register,
// and feeds decode through the IF/ID skid register. Handles redirect and halt.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W      = cpu_types_pkg::WORD_BITS,
  parameter bit          RESET_VALID = 1'b0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] curr_pc,
  input  logic [WORD_W-1:0] npc,
  output logic              pc_en,
  output logic [WORD_W-1:0] new_pc,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic [WORD_W-1:0] ifid_npc,
  output logic              halted
);

  fetch_state_t state_q, state_d;
  logic         run;
  logic         fire;
  logic         flush;
  logic         skid_valid;
  ifid_t        fetched;
  ifid_t        ifid_out;

  assign run   = (state_q == RUN);
  assign iaddr = curr_pc;
  // A full skid means the output is blocked; stop requesting until it drains.
  assign iREN  = run && !skid_valid && !halt_req;
  assign fire  = iREN && ihit;
  assign flush = run && redirect;

  assign fetched = '{instr: iload, pc: curr_pc, npc: npc};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect wins over fire and halt_req; HALTED ignores everything until reset.
  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    new_pc  = npc;
    if (run) begin
      if (redirect) begin
        pc_en  = 1'b1;
        new_pc = redirect_pc;
      end else begin
        pc_en = fire;
        if (halt_req) begin
          state_d = HALTED;
        end
      end
    end
  end

  ifid_skid_reg #(
    .T           (ifid_t),
    .RESET_VALID (RESET_VALID)
  ) u_ifid (
    .CLK          (CLK),
    .nRST         (nRST),
    .flush_i      (flush),
    .in_valid_i   (fire && !flush),
    .in_data_i    (fetched),
    .out_ready_i  (!stall),
    .out_valid_o  (ifid_valid),
    .out_data_o   (ifid_out),
    .skid_valid_o (skid_valid)
  );

  assign ifid_instr = ifid_out.instr;
  assign ifid_pc    = ifid_out.pc;
  assign ifid_npc   = ifid_out.npc;
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID words into a
// queue; a monitor pops and compares each word as decode consumes it.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   total = 0;
  int   bad = 0;
  ifid_t exp_q[$];

  always #5 clk = ~clk;

  fetch_stage_if bus (.CLK(clk), .nRST(nrst));

  fetch_stage #(.WORD_W(32), .RESET_VALID(1'b0)) dut (
    .CLK         (clk),
    .nRST        (nrst),
    .curr_pc     (bus.curr_pc),
    .npc         (bus.npc),
    .pc_en       (bus.pc_en),
    .new_pc      (bus.new_pc),
    .iREN        (bus.iREN),
    .iaddr       (bus.iaddr),
    .ihit        (bus.ihit),
    .iload       (bus.iload),
    .stall       (bus.stall),
    .redirect    (bus.redirect),
    .redirect_pc (bus.redirect_pc),
    .halt_req    (bus.halt_req),
    .ifid_valid  (bus.ifid_valid),
    .ifid_instr  (bus.ifid_instr),
    .ifid_pc     (bus.ifid_pc),
    .ifid_npc    (bus.ifid_npc),
    .halted      (bus.halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input word_t pc, input bit hit, input word_t load, input bit st,
                       input bit rd, input word_t rpc, input bit hr);
    bus.curr_pc     = pc;
    bus.npc         = pc + 32'd4;
    bus.ihit        = hit;
    bus.iload       = load;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt_req    = hr;
  endtask

  task automatic push(input word_t instr, input word_t pc);
    exp_q.push_back('{instr: instr, pc: pc, npc: pc + 32'd4});
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Monitor: a word is consumed on the coming edge when valid and not stalled.
  always @(negedge clk) begin
    ifid_t got;
    ifid_t e;
    if (nrst && bus.ifid_valid && !bus.stall) begin
      got = '{instr: bus.ifid_instr, pc: bus.ifid_pc, npc: bus.ifid_npc};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ifid_unexpected got=%h want=none @%0t", got, $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL ifid_word got=%h want=%h @%0t", got, e, $time);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    chk("rst_valid", 32'(bus.ifid_valid), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_instr", bus.ifid_instr, 32'h0);
    chk("rst_pc", bus.ifid_pc, 32'h0);
    chk("rst_npc", bus.ifid_npc, 32'h0);
    #4;
    nrst = 1'b1;

    // Streaming, one word per cycle
    for (int k = 0; k < 4; k++) begin
      drive(32'(4 * k), 1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("stream_pc_en", 32'(bus.pc_en), 32'h1);
      chk("stream_new_pc", bus.new_pc, 32'(4 * k + 4));
      chk("stream_iaddr", bus.iaddr, 32'(4 * k));
      if (k > 0) begin
        chk("stream_nobubble", 32'(bus.ifid_valid), 32'h1);
        chk("stream_instr", bus.ifid_instr, 32'hA0 + 32'(k - 1));
      end
      push(32'hA0 + 32'(k), 32'(4 * k));
      cyc();
    end

    // Back-pressure into the skid
    drive(32'h0, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0, 1'b0);
    push(32'hA0, 32'h0);
    cyc();
    drive(32'h4, 1'b1, 32'hA1, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("bp_pc_en", 32'(bus.pc_en), 32'h1);
    chk("bp_hold_a0", bus.ifid_instr, 32'hA0);
    push(32'hA1, 32'h4);
    cyc();
    drive(32'h8, 1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("bp_iren_off", 32'(bus.iREN), 32'h0);
    chk("bp_pc_en_off", 32'(bus.pc_en), 32'h0);
    chk("bp_still_a0", bus.ifid_instr, 32'hA0);
    cyc();
    drive(32'h8, 1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("bp_drain_iren", 32'(bus.iREN), 32'h0);
    chk("bp_drain_pc_en", 32'(bus.pc_en), 32'h0);
    cyc();
    drive(32'h8, 1'b1, 32'hA2, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("bp_skid_out", bus.ifid_instr, 32'hA1);
    chk("bp_resume_iren", 32'(bus.iREN), 32'h1);
    chk("bp_resume_new_pc", bus.new_pc, 32'hC);
    push(32'hA2, 32'h8);
    cyc();

    // Miss wait
    for (int i = 0; i < 3; i++) begin
      drive(32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("miss_pc_en", 32'(bus.pc_en), 32'h0);
      chk("miss_iren", 32'(bus.iREN), 32'h1);
      if (i > 0) chk("miss_bubble", 32'(bus.ifid_valid), 32'h0);
      cyc();
    end
    drive(32'h10, 1'b1, 32'hBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("miss_hit_pc_en", 32'(bus.pc_en), 32'h1);
    chk("miss_hit_new_pc", bus.new_pc, 32'h14);
    push(32'hBEEF, 32'h10);
    cyc();
    drive(32'h14, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("miss_instr", bus.ifid_instr, 32'hBEEF);
    chk("miss_ifid_pc", bus.ifid_pc, 32'h10);
    chk("miss_ifid_npc", bus.ifid_npc, 32'h14);
    cyc();

    // Redirect with ifid and skid full under stall
    drive(32'h20, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 1'b0);
    push(32'hC0, 32'h20);
    cyc();
    drive(32'h24, 1'b1, 32'hC1, 1'b1, 1'b0, 32'h0, 1'b0);
    push(32'hC1, 32'h24);
    cyc();
    drive(32'h28, 1'b1, 32'hC2, 1'b1, 1'b1, 32'h200, 1'b0);
    #1;
    chk("redir_pc_en", 32'(bus.pc_en), 32'h1);
    chk("redir_new_pc", bus.new_pc, 32'h200);
    exp_q.delete();
    cyc();
    drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("redir_flush_valid", 32'(bus.ifid_valid), 32'h0);
    chk("redir_flush_skid", 32'(bus.iREN), 32'h1);
    cyc();
    drive(32'h200, 1'b1, 32'h5A5A, 1'b0, 1'b1, 32'h300, 1'b0);
    #1;
    chk("squash_pc_en", 32'(bus.pc_en), 32'h1);
    chk("squash_new_pc", bus.new_pc, 32'h300);
    cyc();
    drive(32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("squash_valid", 32'(bus.ifid_valid), 32'h0);
    cyc();

    // Halt
    drive(32'h2C, 1'b1, 32'hD0, 1'b0, 1'b0, 32'h0, 1'b0);
    push(32'hD0, 32'h2C);
    cyc();
    drive(32'h30, 1'b1, 32'hD1, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("halt_iren", 32'(bus.iREN), 32'h0);
    chk("halt_pc_en", 32'(bus.pc_en), 32'h0);
    chk("halt_not_yet", 32'(bus.halted), 32'h0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(32'h30, 1'b1, 32'hD2, 1'b0, 1'(i % 2), 32'h400, 1'b0);
      #1;
      chk("halted_flag", 32'(bus.halted), 32'h1);
      chk("halted_pc_en", 32'(bus.pc_en), 32'h0);
      chk("halted_iren", 32'(bus.iREN), 32'h0);
      if (i > 0) chk("halted_drained", 32'(bus.ifid_valid), 32'h0);
      cyc();
    end

    // Leave HALTED through reset
    drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    nrst = 1'b0;
    #1;
    chk("reset_unhalt", 32'(bus.halted), 32'h0);
    nrst = 1'b1;
    cyc();

    // Async reset with ifid and skid full
    drive(32'h40, 1'b1, 32'hE0, 1'b0, 1'b0, 32'h0, 1'b0);
    push(32'hE0, 32'h40);
    cyc();
    drive(32'h44, 1'b1, 32'hE1, 1'b1, 1'b0, 32'h0, 1'b0);
    push(32'hE1, 32'h44);
    cyc();
    drive(32'h48, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("pre_rst_skid_full", 32'(bus.iREN), 32'h0);
    chk("pre_rst_instr", bus.ifid_instr, 32'hE0);
    nrst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ifid_valid), 32'h0);
    chk("arst_skid", 32'(bus.iREN), 32'h1);
    chk("arst_halted", 32'(bus.halted), 32'h0);
    chk("arst_instr", bus.ifid_instr, 32'h0);
    exp_q.delete();
    #1;
    nrst = 1'b1;
    cyc();
    drive(32'h40, 1'b1, 32'hF0, 1'b0, 1'b0, 32'h0, 1'b0);
    push(32'hF0, 32'h40);
    cyc();
    drive(32'h44, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("post_rst_instr", bus.ifid_instr, 32'hF0);
    cyc();
    cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
